// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg: shared I/O window constants, register decode and STATUS layout.
package mem_io_responder_pkg;

    localparam logic [1:0]  IO_SEL             = 2'b11;
    localparam logic [31:0] IO_DATA_ADDR       = 32'h30000;
    localparam logic [31:0] IO_STATUS_ADDR     = 32'h30004;
    localparam int          STATUS_TX_FULL_BIT = 0;
    localparam int          STATUS_RX_NE_BIT   = 1;

    typedef enum logic [1:0] {REG_RAM, REG_DATA, REG_STATUS, REG_NONE} io_reg_e;

    // Only addr[17:16] selects the window and only addr[2:0] picks the I/O register.
    function automatic io_reg_e io_decode(input logic [31:0] addr);
        return addr[17:16] != IO_SEL             ? REG_RAM    :
               addr[2:0] == IO_DATA_ADDR[2:0]    ? REG_DATA   :
               addr[2:0] == IO_STATUS_ADDR[2:0]  ? REG_STATUS : REG_NONE;
    endfunction

endpackage

// File: rtl/mem_io_responder_fifo.sv
// byte_fifo: byte FIFO with same-cycle push+pop, a push accepted when full if a pop frees the slot.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_push,
    input  logic [7:0]               i_wdata,
    input  logic                     i_pop,
    output logic [7:0]               o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_drop,
    output logic [$clog2(DEPTH):0]   o_count_next
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full       = r_count == (AW+1)'(DEPTH);
    assign o_empty      = r_count == '0;
    assign w_pop        = i_en && i_pop && !o_empty;
    assign w_push       = i_en && i_push && (!o_full || w_pop);
    assign o_drop       = i_en && i_push && !w_push;
    assign o_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign o_head       = o_empty ? 8'h00 : r_mem[r_rptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_push);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= o_count_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: RAM-bus responder with byte RAM, UART TX/RX FIFO window, back-pressure and sim halt.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 8,
    parameter int RX_DEPTH       = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rdy,
    input  logic        i_bus_rw,
    input  logic [31:0] i_bus_addr,
    input  logic [7:0]  i_bus_wdata,
    output logic [7:0]  o_bus_rdata,
    output logic        o_uart_full,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_tx_overflow,
    output logic        o_rx_overflow,
    output logic        o_sim_halt
);
    localparam int TXW = $clog2(TX_DEPTH);
    // Two spare slots absorb the controller's in-flight beat and its post-write wait.
    localparam logic [TXW:0] TX_MARK = (TXW+1)'(TX_DEPTH - 2);

    logic [7:0]               r_ram [2**RAM_ADDR_WIDTH];
    logic [7:0]               r_bus_rdata;
    logic                     r_uart_full;
    logic                     r_tx_overflow;
    logic                     r_rx_overflow;
    logic                     r_sim_halt;
    io_reg_e                  w_reg;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;
    logic                     w_tx_empty;
    logic                     w_tx_full;
    logic                     w_tx_drop;
    logic [TXW:0]             w_tx_count_next;
    logic [7:0]               w_rx_head;
    logic                     w_rx_empty;
    logic                     w_rx_drop;
    logic                     w_unused_rx_full;
    logic [$clog2(RX_DEPTH):0] w_unused_rx_count;
    logic [7:0]               w_status;
    logic [7:0]               w_io_rdata;

    assign w_reg     = io_decode(i_bus_addr);
    assign w_ram_idx = i_bus_addr[RAM_ADDR_WIDTH-1:0];

    always_comb begin
        w_status                     = '0;
        w_status[STATUS_RX_NE_BIT]   = !w_rx_empty;
        w_status[STATUS_TX_FULL_BIT] = w_tx_full;
        w_io_rdata = w_reg == REG_DATA ? w_rx_head : w_reg == REG_STATUS ? w_status : 8'h00;
    end

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_rdy),
        .i_push       (i_bus_rw && w_reg == REG_DATA),
        .i_wdata      (i_bus_wdata),
        .i_pop        (i_tx_ready),
        .o_head       (o_tx_data),
        .o_full       (w_tx_full),
        .o_empty      (w_tx_empty),
        .o_drop       (w_tx_drop),
        .o_count_next (w_tx_count_next)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_rdy),
        .i_push       (i_rx_valid),
        .i_wdata      (i_rx_data),
        .i_pop        (!i_bus_rw && w_reg == REG_DATA),
        .o_head       (w_rx_head),
        .o_full       (w_unused_rx_full),
        .o_empty      (w_rx_empty),
        .o_drop       (w_rx_drop),
        .o_count_next (w_unused_rx_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bus_rdata   <= '0;
            r_uart_full   <= 1'b0;
            r_tx_overflow <= 1'b0;
            r_rx_overflow <= 1'b0;
            r_sim_halt    <= 1'b0;
        end else if (i_rdy) begin
            if (!i_bus_rw) r_bus_rdata <= w_reg == REG_RAM ? r_ram[w_ram_idx] : w_io_rdata;
            r_uart_full   <= w_tx_count_next >= TX_MARK;
            r_tx_overflow <= r_tx_overflow || w_tx_drop;
            r_rx_overflow <= r_rx_overflow || w_rx_drop;
            r_sim_halt    <= i_bus_rw && w_reg == REG_STATUS;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rdy && i_bus_rw && w_reg == REG_RAM) r_ram[w_ram_idx] <= i_bus_wdata;
    end

    assign o_bus_rdata   = r_bus_rdata;
    assign o_uart_full   = r_uart_full;
    assign o_tx_valid    = !w_tx_empty;
    assign o_tx_overflow = r_tx_overflow;
    assign o_rx_overflow = r_rx_overflow;
    assign o_sim_halt    = r_sim_halt;

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed scenario tasks with hand-computed expectations for mem_io_responder.
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        rst_n, rdy, bus_rw, tx_ready, rx_valid;
    logic [31:0] bus_addr;
    logic [7:0]  bus_wdata, rx_data, bus_rdata, tx_data;
    logic        uart_full, tx_valid, tx_overflow, rx_overflow, sim_halt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_io_responder dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rdy(rdy), .i_bus_rw(bus_rw), .i_bus_addr(bus_addr),
        .i_bus_wdata(bus_wdata), .o_bus_rdata(bus_rdata), .o_uart_full(uart_full),
        .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready), .i_rx_valid(rx_valid),
        .i_rx_data(rx_data), .o_tx_overflow(tx_overflow), .o_rx_overflow(rx_overflow),
        .o_sim_halt(sim_halt)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic rw, input logic [31:0] a, input logic [7:0] d);
        bus_rw = rw; bus_addr = a; bus_wdata = d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rdy = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        bus(1'b0, 32'h0, 8'h00);
        #3;
        checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", bus_rdata); end
        checks++; if (uart_full !== 1'b0) begin errors++; $display("FAIL reset_uart_full: got %b want 0", uart_full); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (tx_overflow !== 1'b0 || rx_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b%b want 00", tx_overflow, rx_overflow); end
        checks++; if (sim_halt !== 1'b0) begin errors++; $display("FAIL reset_sim_halt: got %b want 0", sim_halt); end
        step; step;
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_ram;
        bus(1'b1, 32'h10, 8'hA5); step;
        bus(1'b0, 32'h10, 8'h00); step;
        checks++; if (bus_rdata !== 8'hA5) begin errors++; $display("FAIL ram_wr_rd: got %h want a5", bus_rdata); end
        bus(1'b1, 32'h11, 8'h3C); step;
        bus(1'b0, 32'h10, 8'h00); step;
        checks++; if (bus_rdata !== 8'hA5) begin errors++; $display("FAIL ram_b2b_0: got %h want a5", bus_rdata); end
        bus(1'b0, 32'h11, 8'h00); step;
        checks++; if (bus_rdata !== 8'h3C) begin errors++; $display("FAIL ram_b2b_1: got %h want 3c", bus_rdata); end
        rdy = 1'b0; bus(1'b1, 32'h10, 8'h77); step;
        checks++; if (bus_rdata !== 8'h3C) begin errors++; $display("FAIL rdy_hold_rdata: got %h want 3c", bus_rdata); end
        rdy = 1'b1; bus(1'b0, 32'h10, 8'h00); step;
        checks++; if (bus_rdata !== 8'hA5) begin errors++; $display("FAIL rdy_blocks_write: got %h want a5", bus_rdata); end
        bus(1'b0, 32'h20010, 8'h00); step;
        checks++; if (bus_rdata !== 8'hA5) begin errors++; $display("FAIL ram_alias_bit17: got %h want a5", bus_rdata); end
        bus(1'b0, 32'h0, 8'h00);
    endtask

    task automatic test_tx;
        bus(1'b1, 32'h30000, 8'h41); step;
        bus(1'b1, 32'h30000, 8'h42); step;
        bus(1'b0, 32'h0, 8'h00);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL tx_head: got %b/%h want 1/41", tx_valid, tx_data); end
        tx_ready = 1'b1; step; tx_ready = 1'b0;
        checks++; if (tx_data !== 8'h42) begin errors++; $display("FAIL tx_pop: got %h want 42", tx_data); end
        tx_ready = 1'b1; step; tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained: got %b want 0", tx_valid); end
    endtask

    task automatic test_uart_full;
        for (int i = 1; i <= 9; i++) begin
            bus(1'b1, 32'h30000, 8'(i)); step;
            if (i == 5) begin checks++; if (uart_full !== 1'b0) begin errors++; $display("FAIL uart_full_at5: got %b want 0", uart_full); end end
            if (i == 6) begin checks++; if (uart_full !== 1'b1) begin errors++; $display("FAIL uart_full_at6: got %b want 1", uart_full); end end
            if (i == 8) begin checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL tx_ovf_at8: got %b want 0", tx_overflow); end end
        end
        bus(1'b0, 32'h0, 8'h00);
        checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL tx_ovf_at9: got %b want 1", tx_overflow); end
        bus(1'b0, 32'h30004, 8'h00); step;
        bus(1'b0, 32'h0, 8'h00);
        checks++; if (bus_rdata !== 8'h01) begin errors++; $display("FAIL status_tx_full: got %h want 01", bus_rdata); end
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (tx_data !== 8'(i)) begin errors++; $display("FAIL tx_drain_%0d: got %h want %h", i, tx_data, 8'(i)); end
            step;
        end
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0 || uart_full !== 1'b0) begin errors++; $display("FAIL tx_after_drain: got %b/%b want 0/0", tx_valid, uart_full); end
    endtask

    task automatic test_rx;
        rx_valid = 1'b1; rx_data = 8'h5A; step; rx_valid = 1'b0;
        bus(1'b0, 32'h30004, 8'h00); step;
        checks++; if (bus_rdata !== 8'h02) begin errors++; $display("FAIL status_rx_ne: got %h want 02", bus_rdata); end
        bus(1'b0, 32'h30000, 8'h00); step;
        checks++; if (bus_rdata !== 8'h5A) begin errors++; $display("FAIL rx_read: got %h want 5a", bus_rdata); end
        step;
        checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL rx_read_empty: got %h want 00", bus_rdata); end
        bus(1'b0, 32'h30004, 8'h00); step;
        checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL status_empty: got %h want 00", bus_rdata); end
        rdy = 1'b0; rx_valid = 1'b1; rx_data = 8'h99; bus(1'b0, 32'h30000, 8'h00); step;
        rdy = 1'b1; rx_valid = 1'b0; step;
        checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL rdy_blocks_rx: got %h want 00", bus_rdata); end
        rx_valid = 1'b1; rx_data = 8'h77; step; rx_valid = 1'b0;
        checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL rx_empty_pushpop: got %h want 00", bus_rdata); end
        step;
        checks++; if (bus_rdata !== 8'h77) begin errors++; $display("FAIL rx_empty_stored: got %h want 77", bus_rdata); end
        bus(1'b0, 32'h0, 8'h00);
    endtask

    task automatic test_rx_full;
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin rx_data = 8'h10 + 8'(i); step; end
        rx_data = 8'h18; bus(1'b0, 32'h30000, 8'h00); step; rx_valid = 1'b0;
        checks++; if (bus_rdata !== 8'h10) begin errors++; $display("FAIL rx_full_pushpop: got %h want 10", bus_rdata); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL rx_full_no_ovf: got %b want 0", rx_overflow); end
        for (int i = 1; i <= 8; i++) begin
            step;
            checks++; if (bus_rdata !== 8'h10 + 8'(i)) begin errors++; $display("FAIL rx_drain_%0d: got %h want %h", i, bus_rdata, 8'h10 + 8'(i)); end
        end
        step;
        checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL rx_drained: got %h want 00", bus_rdata); end
        bus(1'b0, 32'h0, 8'h00);
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin rx_data = 8'(i); step; end
        rx_valid = 1'b0;
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL rx_ovf: got %b want 1", rx_overflow); end
    endtask

    task automatic test_halt;
        bus(1'b1, 32'h30004, 8'hFF); step;
        bus(1'b0, 32'h0, 8'h00);
        checks++; if (sim_halt !== 1'b1) begin errors++; $display("FAIL halt_high: got %b want 1", sim_halt); end
        step;
        checks++; if (sim_halt !== 1'b0) begin errors++; $display("FAIL halt_pulse: got %b want 0", sim_halt); end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 6; i++) begin bus(1'b1, 32'h30000, 8'hC0 + 8'(i)); step; end
        bus(1'b0, 32'h0, 8'h00);
        checks++; if (uart_full !== 1'b1 || tx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_tx: got %b/%b want 1/1", uart_full, tx_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0 || uart_full !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL async_reset_tx: got %b/%b/%h want 0/0/00", tx_valid, uart_full, tx_data); end
        checks++; if (tx_overflow !== 1'b0 || rx_overflow !== 1'b0) begin errors++; $display("FAIL async_reset_ovf: got %b%b want 00", tx_overflow, rx_overflow); end
        step;
        rst_n = 1'b1;
        bus(1'b0, 32'h30004, 8'h00); step;
        checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL post_reset_status: got %h want 00", bus_rdata); end
    endtask

    initial begin
        test_reset;
        test_ram;
        test_tx;
        test_uart_full;
        test_rx;
        test_rx_full;
        test_halt;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
